// File: rtl/ram_dp_param.sv
// Simple dual-port RAM with byte enables, self-clearing after reset, and a
// selectable read latency and same-address read-during-write policy.
module ram_dp_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                w_en,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_valid,
  output logic                init_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {INIT, READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [NB-1:0]     mem_be;

  logic              rd_issue;
  logic              wr_hit;
  logic              v1_reg;
  logic [DATA_W-1:0] q_reg;
  logic [NB-1:0]     byp_be_reg;
  logic [DATA_W-1:0] byp_data_reg;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(DEPTH - 1))
          state_next = READY;
      end
      default: ;
    endcase
  end

  assign init_done = (state_reg == READY);

  // The clear sequence borrows the user write port while in INIT.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = w_addr;
    mem_wd = w_data;
    mem_be = w_be;
    if (state_reg == INIT) begin
      mem_we = 1'b1;
      mem_wa = cnt_reg;
      mem_wd = '0;
      mem_be = '1;
    end else begin
      mem_we = cs & w_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < NB; i++)
        if (mem_be[i])
          mem[mem_wa][i*8 +: 8] <= mem_wd[i*8 +: 8];
    end
  end

  assign rd_issue = (state_reg == READY) & cs & r_en;
  assign wr_hit   = (RDW_MODE != 0) && cs && w_en && (w_addr == r_addr);

  // The array read stays read-first; write-first is built by merging the
  // captured write lanes after the registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg       <= 1'b0;
      q_reg        <= '0;
      byp_be_reg   <= '0;
      byp_data_reg <= '0;
    end else begin
      v1_reg <= rd_issue;
      if (rd_issue) begin
        q_reg        <= mem[r_addr];
        byp_be_reg   <= wr_hit ? w_be : '0;
        byp_data_reg <= w_data;
      end
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign rd_word[gi*8 +: 8] = byp_be_reg[gi] ? byp_data_reg[gi*8 +: 8]
                                                : q_reg[gi*8 +: 8];
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              v2_reg;
    logic [DATA_W-1:0] r2_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_reg <= 1'b0;
        r2_reg <= '0;
      end else begin
        v2_reg <= v1_reg;
        if (v1_reg)
          r2_reg <= rd_word;
      end
    end
    assign r_data  = r2_reg;
    assign r_valid = v2_reg;
  end else begin : g_lat1
    assign r_data  = rd_word;
    assign r_valid = v1_reg;
  end
endmodule

// File: tb/tb_ram_dp_param.sv
// Directed/random bench: a read-first RD_LAT=1 RAM and a write-first RD_LAT=2
// RAM share stimulus; a reference memory feeds per-DUT expectation queues.
module tb_ram_dp_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [3:0]  w_addr = '0, r_addr = '0, w_be = '0;
  logic [31:0] w_data = '0;
  logic [31:0] r_data_a, r_data_b;
  logic        r_valid_a, r_valid_b, init_done_a, init_done_b;

  always #5 clk = ~clk;

  ram_dp_param #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .cs(cs), .w_en(w_en), .r_en(r_en),
    .w_addr(w_addr), .r_addr(r_addr), .w_data(w_data), .w_be(w_be),
    .r_data(r_data_a), .r_valid(r_valid_a), .init_done(init_done_a));

  ram_dp_param #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .cs(cs), .w_en(w_en), .r_en(r_en),
    .w_addr(w_addr), .r_addr(r_addr), .w_data(w_data), .w_be(w_be),
    .r_data(r_data_b), .r_valid(r_valid_b), .init_done(init_done_b));

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ref_mem [16];
  bit          ready = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        rst_seen = 1'b0;
  logic [31:0] last_a = '0, last_b = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Output monitors: cyc equals the edge count, so latency is checked exactly.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      check("rst_valid_a", 32'(r_valid_a), 32'd0);
      check("rst_data_a", r_data_a, 32'd0);
      last_a = '0;
    end else if (r_valid_a) begin
      if (qa.size() == 0) check("unexpected_valid_a", 32'(r_valid_a), 32'd0);
      else begin
        e = qa.pop_front();
        check("latency_a", 32'(cyc), 32'(e.c));
        check("data_a", r_data_a, e.d);
      end
      last_a = r_data_a;
    end else begin
      check("hold_a", r_data_a, last_a);
      if (qa.size() > 0 && qa[0].c <= cyc) begin
        check("missing_valid_a", 32'(r_valid_a), 32'd1);
        void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      check("rst_valid_b", 32'(r_valid_b), 32'd0);
      check("rst_data_b", r_data_b, 32'd0);
      last_b = '0;
    end else if (r_valid_b) begin
      if (qb.size() == 0) check("unexpected_valid_b", 32'(r_valid_b), 32'd0);
      else begin
        e = qb.pop_front();
        check("latency_b", 32'(cyc), 32'(e.c));
        check("data_b", r_data_b, e.d);
      end
      last_b = r_data_b;
    end else begin
      check("hold_b", r_data_b, last_b);
      if (qb.size() > 0 && qb[0].c <= cyc) begin
        check("missing_valid_b", 32'(r_valid_b), 32'd1);
        void'(qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic we, input logic re,
                       input logic [3:0] wa, input logic [3:0] ra,
                       input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    logic [31:0] old, mrg;
    cs = c; w_en = we; r_en = re;
    w_addr = wa; r_addr = ra; w_data = wd; w_be = be;
    if (ready && c && re) begin
      old = ref_mem[ra];
      mrg = old;
      if (we && wa == ra)
        for (int i = 0; i < 4; i++)
          if (be[i]) mrg[i*8 +: 8] = wd[i*8 +: 8];
      e.d = old; e.c = cyc + 1; qa.push_back(e);
      e.d = mrg; e.c = cyc + 2; qb.push_back(e);
    end
    if (ready && c && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[wa][i*8 +: 8] = wd[i*8 +: 8];
    tick();
    cs = 1'b0; w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b1, 1'b0, 1'b1, 4'd0, a, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, 1'b1, 1'b0, a, 4'd0, d, be);
  endtask

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
          $urandom, 4'($urandom));
  endtask

  // Reads still completing before the reset edge are kept; later ones vanish.
  task automatic do_reset(input int n);
    rst   = 1'b1;
    ready = 1'b0;
    while (qa.size() > 0 && qa[$].c > cyc) void'(qa.pop_back());
    while (qb.size() > 0 && qb[$].c > cyc) void'(qb.pop_back());
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_init(input bit noisy);
    for (int k = 0; k < 16; k++) begin
      check("init_low_a", 32'(init_done_a), 32'd0);
      check("init_low_b", 32'(init_done_b), 32'd0);
      if (noisy) drive(1'b1, 1'b1, 1'b1, 4'($urandom), 4'($urandom), 32'hFFFF_FFFF, 4'hF);
      else tick();
    end
    check("init_high_a", 32'(init_done_a), 32'd1);
    check("init_high_b", 32'(init_done_b), 32'd1);
    ready = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (qa.size() > 0 || qb.size() > 0); k++) tick();
    check("drain", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    do_reset(2);
    wait_init(1'b0);

    rd(4'd5);
    wr(4'd3, 32'hDEAD_BEEF, 4'b1111);
    rd(4'd3);
    wr(4'd3, 32'h0000_AA00, 4'b0010);
    rd(4'd3);
    wr(4'd7, 32'h1111_1111, 4'b1111);
    drive(1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 32'h2222_2222, 4'b1111);
    drive(1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 32'h3333_3333, 4'b0101);
    rd(4'd7);
    wr(4'd3, 32'hFFFF_FFFF, 4'b0000);
    rd(4'd3);
    drive(1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 32'hFFFF_FFFF, 4'b1111);
    rd(4'd2);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 32'd0, 4'd0);

    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b1, 1'b1, 4'(i + 8), 4'(i), $urandom, 4'($urandom));
    repeat (60) drive_random();
    drain();

    // Reset one cycle after a read: the RD_LAT=2 read must never complete.
    rd(4'd3);
    do_reset(1);
    wait_init(1'b1);
    rd(4'd3);
    rd(4'd7);

    // Reset in the middle of clearing restarts the full sequence.
    do_reset(1);
    repeat (5) drive_random();
    do_reset(1);
    wait_init(1'b0);
    for (int i = 0; i < 4; i++) rd(4'(i));
    repeat (20) drive_random();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
